// File: rtl/axi_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_slave
// Description : AXI4-Lite register-file slave. NUM_REGS registers of
//               DATA_WIDTH bits, byte-strobed writes, one outstanding write
//               and one outstanding read, channels run concurrently.
//               Optional macro AXI_LITE_SLAVE_SLVERR_EN: out-of-range
//               accesses answer SLVERR (2'b10) instead of OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    // write response channel
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    // read data channel
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    // user side
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int c_STRB_W   = DATA_WIDTH / 8;
    localparam int c_ADDR_LSB = $clog2(c_STRB_W);
    localparam int c_IDX_W    = ADDR_WIDTH - c_ADDR_LSB;
    localparam int c_SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [c_IDX_W-1:0] c_NUM_REGS  = c_IDX_W'(NUM_REGS);
    localparam logic [1:0]         c_RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLAVE_SLVERR_EN
    localparam logic [1:0]         c_RESP_OOR  = 2'b10;
`else
    localparam logic [1:0]         c_RESP_OOR  = 2'b00;
`endif

    // Elaboration-time guard on the supported configuration space
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("axi_lite_slave: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
        $error("axi_lite_slave: NUM_REGS must be in 1..256");
    end

    typedef enum logic [1:0] {
        WR_WAIT  = 2'd0,
        WR_WRITE = 2'd1,
        WR_RESP  = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    wr_state_t               r_wr_state;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [c_IDX_W-1:0]      r_awidx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]     r_wstrb;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_done_nxt;
    logic                    w_w_done_nxt;
    logic                    w_wr_in_range;
    logic                    w_commit;

    assign w_aw_hs       = awvalid & r_awready;
    assign w_w_hs        = wvalid & r_wready;
    assign w_aw_done_nxt = r_aw_done | w_aw_hs;
    assign w_w_done_nxt  = r_w_done | w_w_hs;
    assign w_wr_in_range = (r_awidx < c_NUM_REGS);
    assign w_commit      = (r_wr_state == WR_WRITE);

    // Write FSM: collect AW and W in any order, commit for one cycle, then hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= WR_WAIT;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
        end else begin
            case (r_wr_state)
                WR_WAIT: begin
                    if (w_aw_hs) begin
                        r_awidx <= awaddr[ADDR_WIDTH-1:c_ADDR_LSB];
                    end
                    if (w_w_hs) begin
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                    end
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        // Both beats held: close both channels until the response retires
                        r_wr_state <= WR_WRITE;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                    end else begin
                        // Also raises the readies on the first edge after reset
                        r_aw_done  <= w_aw_done_nxt;
                        r_w_done   <= w_w_done_nxt;
                        r_awready  <= ~w_aw_done_nxt;
                        r_wready   <= ~w_w_done_nxt;
                    end
                end
                WR_WRITE: begin
                    r_wr_state <= WR_RESP;
                    r_bvalid   <= 1'b1;
                    r_bresp    <= w_wr_in_range ? c_RESP_OKAY : c_RESP_OOR;
                end
                WR_RESP: begin
                    if (bready) begin
                        r_wr_state <= WR_WAIT;
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                default: begin
                    r_wr_state <= WR_WAIT;
                end
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

    // ------------------------------------------------------------------
    // Register file. Out-of-range indices never match any slot, so such
    // writes change nothing and raise no pulse.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] r_q;

        assign w_hit = w_commit && (r_awidx == c_IDX_W'(i));

        // Byte-lane merge of the captured write beat into this register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_hit) begin
                for (int b = 0; b < c_STRB_W; b++) begin
                    if (r_wstrb[b]) begin
                        r_q[8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_q;
        assign reg_wr_pulse[i]                   = w_hit;
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t               r_rd_state;
    logic                    r_arready;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    logic                    w_ar_hs;
    logic [c_IDX_W-1:0]      w_rd_idx;
    logic [c_SEL_W-1:0]      w_rd_sel;
    logic                    w_rd_in_range;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    assign w_ar_hs       = arvalid & r_arready;
    assign w_rd_idx      = araddr[ADDR_WIDTH-1:c_ADDR_LSB];
    assign w_rd_sel      = w_rd_idx[c_SEL_W-1:0];
    assign w_rd_in_range = (w_rd_idx < c_NUM_REGS);
    // reg_q still holds the pre-commit value on a commit edge, so a
    // colliding read returns the old contents
    assign w_rd_data     = w_rd_in_range ? reg_q[int'(w_rd_sel)*DATA_WIDTH +: DATA_WIDTH]
                                         : '0;

    // Read FSM: register the addressed word on AR handshake, hold it until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_state <= RD_RESP;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_in_range ? c_RESP_OKAY : c_RESP_OOR;
                    end else begin
                        r_arready  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        r_rd_state <= RD_IDLE;
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                    end
                end
                default: begin
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    // Byte-offset address bits select nothing inside a word
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{awaddr[c_ADDR_LSB-1:0], araddr[c_ADDR_LSB-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_slave
// Description : Scoreboard bench for axi_lite_slave (default parameters).
//               Stimulus pushes expected B/R responses; a negedge monitor
//               pops and compares whenever a response handshake occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI_LITE_SLAVE_SLVERR_EN
    localparam logic [1:0] ERR  = 2'b10;
`else
    localparam logic [1:0] ERR  = 2'b00;
`endif

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     reg_wr_pulse;

    axi_lite_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  exp_b_q [$];
    rexp_t       exp_r_q [$];
    logic [31:0] model [NR];
    logic [1:0]  mon_b;
    rexp_t       mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++) begin
            check($sformatf("reg_q[%0d]", i), reg_q[i*DW +: DW], model[i]);
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            if (!bvalid && !rvalid && awready && wready && arready) break;
            cyc++;
        end
        if (cyc >= 50) check("idle_timeout", 64'd0, 64'd1);
    endtask

    // Response monitor: every accepted B or R beat is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_b = exp_b_q.pop_front();
                    check("bresp", bresp, mon_b);
                end
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_r = exp_r_q.pop_front();
                    check("rdata", rdata, mon_r.data);
                    check("rresp", rresp, mon_r.resp);
                end
            end
        end
    end

    // Write with W presented w_lead cycles ahead of AW (0 = same cycle)
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead);
        logic       aw_done, w_done, aw_take, w_take;
        int         cyc;
        int         idx;
        logic [7:0] exp_pulse;
        idx       = int'(addr >> 2);
        exp_pulse = (idx < NR) ? (8'd1 << idx) : 8'd0;
        exp_b_q.push_back((idx < NR) ? OKAY : ERR);
        @(posedge clk); #1;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        bready  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            aw_take = awvalid && awready;
            w_take  = wvalid && wready;
            if (w_done && !aw_done) check("wready_low_after_w", wready, 64'd0);
            @(posedge clk); #1;
            if (aw_take) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_take)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            cyc++;
            if (w_done && !aw_done && !awvalid && cyc >= w_lead) awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 64'd0, 64'd1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
            return;
        end
        // WRITE cycle
        @(negedge clk);
        check("wr_pulse", reg_wr_pulse, exp_pulse);
        check("awready_in_write", awready, 64'd0);
        check("wready_in_write", wready, 64'd0);
        check("bvalid_in_write", bvalid, 64'd0);
        // first RESP cycle: two cycles after the handshake
        @(negedge clk);
        check("bvalid_rise", bvalid, 64'd1);
        check("wr_pulse_clear", reg_wr_pulse, 64'd0);
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        wait_idle();
        check_regs();
    endtask

    // Read with rready held low for 'hold' cycles after rvalid rises
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold);
        logic  take;
        int    cyc;
        rexp_t e;
        e.data = exp_data;
        e.resp = exp_resp;
        exp_r_q.push_back(e);
        @(posedge clk); #1;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (hold == 0);
        take    = 1'b0;
        cyc     = 0;
        while (!take && cyc < 40) begin
            @(negedge clk);
            take = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!take) begin
            check("rd_handshake_timeout", 64'd0, 64'd1);
            rready = 1'b1;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("rvalid_hold", rvalid, 64'd1);
            check("arready_hold", arready, 64'd0);
            check("rdata_hold", rdata, exp_data);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        wait_idle();
    endtask

    initial begin
        rst_n   = 1'b0;
        awaddr  = '0; awvalid = 1'b0;
        wdata   = '0; wstrb   = '0; wvalid = 1'b0;
        bready  = 1'b1;
        araddr  = '0; arvalid = 1'b0;
        rready  = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", awready, 64'd0);
        check("rst_wready", wready, 64'd0);
        check("rst_arready", arready, 64'd0);
        check("rst_bvalid", bvalid, 64'd0);
        check("rst_rvalid", rvalid, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_bresp", bresp, 64'd0);
        check("rst_rresp", rresp, 64'd0);
        check("rst_pulse", reg_wr_pulse, 64'd0);
        check_regs();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_awready", awready, 64'd1);
        check("rel_wready", wready, 64'd1);
        check("rel_arready", arready, 64'd1);

        // Same-cycle AW/W full-word write
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0);
        // W three cycles ahead of AW, low byte only
        do_write(32'h04, 32'h000000AA, 4'h1, 3);
        check("reg1_merge", reg_q[63:32], 32'hDEADBEAA);
        // Read with rready stalled for 5 cycles
        do_read(32'h04, 32'hDEADBEAA, OKAY, 5);

        // Out-of-range write and read (index 16)
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0);
        do_read(32'h40, 32'h0, ERR, 0);

        // Read captured on the same edge that commits a write to that register
        exp_b_q.push_back(OKAY);
        @(posedge clk); #1;
        awaddr = 32'h08; awvalid = 1'b1;
        wdata  = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("coll_aw_ready", awready & wready, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr  = 32'h08; arvalid = 1'b1;
        exp_r_q.push_back('{data: 32'h0, resp: OKAY});
        @(negedge clk);
        check("coll_pulse", reg_wr_pulse, 64'h4);
        check("coll_arready", arready, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_idle();
        model[2] = 32'h12345678;
        check_regs();
        do_read(32'h08, 32'h12345678, OKAY, 0);

        // Byte offset ignored, partial strobe, last register
        do_write(32'h1F, 32'h11223344, 4'h6, 0);
        do_read(32'h1C, 32'h00223300, OKAY, 2);

        // Reset after AW captured but before W
        @(posedge clk); #1;
        awaddr = 32'h0C; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("mid_awready_low", awready, 64'd0);
        check("mid_wready_high", wready, 64'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        check("arst_awready", awready, 64'd0);
        check("arst_wready", wready, 64'd0);
        check("arst_arready", arready, 64'd0);
        check("arst_bvalid", bvalid, 64'd0);
        check("arst_rdata", rdata, 64'd0);
        check_regs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel2_readies", {awready, wready, arready}, 64'h7);
        repeat (3) begin
            @(negedge clk);
            check("rel2_no_bvalid", bvalid, 64'd0);
        end
        do_write(32'h0C, 32'hCAFEF00D, 4'hF, 0);
        do_read(32'h0C, 32'hCAFEF00D, OKAY, 0);

        repeat (2) @(negedge clk);
        check("b_queue_empty", exp_b_q.size(), 64'd0);
        check("r_queue_empty", exp_r_q.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_slave.md
AXI_LITE_SLAVE -- requirements
Module: axi_lite_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width, restricted to 32 or 64.
REQ-003 Parameter NUM_REGS, default 8, SHALL set the register count, range 1..256.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (all logic on rising edge), then rst_n input 1 (asynchronous, active-low).
REQ-005 Write-address ports SHALL be: awaddr in ADDR_WIDTH; awvalid in 1; awready out 1.
REQ-006 Write-data ports SHALL be: wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8 (byte enables); wvalid in 1; wready out 1.
REQ-007 Write-response ports SHALL be: bresp out 2; bvalid out 1; bready in 1.
REQ-008 Read-address ports SHALL be: araddr in ADDR_WIDTH; arvalid in 1; arready out 1.
REQ-009 Read-data ports SHALL be: rdata out DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1.
REQ-010 User-side ports SHALL be: reg_q out NUM_REGS*DATA_WIDTH (register i at bits [i*DATA_WIDTH +: DATA_WIDTH]); reg_wr_pulse out NUM_REGS (one-cycle strobe per written register).

Function
REQ-011 Register index SHALL be awaddr/araddr divided by DATA_WIDTH/8; low byte-offset bits are ignored; index >= NUM_REGS is out-of-range.
REQ-012 Write channel SHALL use a 3-state FSM: WAIT (collecting AW and/or W), WRITE (one cycle, commit), RESP (bvalid held).
REQ-013 In WAIT, awready SHALL be 1 until an AW handshake is captured and wready 1 until a W handshake is captured, independently and in either order, same-cycle capture allowed.
REQ-014 Once both are captured, the FSM SHALL enter WRITE; with awready and wready driven 0 from that edge until RESP exits.
REQ-015 In WRITE, each byte lane with wstrb set SHALL update the indexed register; other lanes keep their value; reg_wr_pulse[index] SHALL be 1 for that cycle only if the index is in range (pulse asserted even when wstrb is all-zero).
REQ-016 bvalid SHALL rise on the edge leaving WRITE and hold with stable bresp until bready is sampled 1; FSM then returns to WAIT with awready=wready=1 next cycle.
REQ-017 bresp SHALL be 2'b00 (OKAY) for in-range writes; out-of-range writes SHALL modify no register.
REQ-018 Read channel SHALL use a 2-state FSM: IDLE (arready=1) and RESP (rvalid=1, arready=0).
REQ-019 An AR handshake in IDLE SHALL register rdata/rresp and assert rvalid on the next edge (1-cycle latency); rdata, rresp stable until rready sampled 1, then IDLE.
REQ-020 Out-of-range reads SHALL return rdata = 0.
REQ-021 Read and write channels SHALL operate concurrently; a read captured in the same cycle as WRITE to the same register SHALL return the pre-write value.
REQ-022 Only one write and one read SHALL be outstanding at a time; no internal buffering beyond one address and one data beat.

Reset
REQ-023 On rst_n low, all registers, reg_q, reg_wr_pulse, bvalid, rvalid, rdata, bresp, rresp and captured address/data SHALL clear to 0 immediately; FSMs to WAIT/IDLE.
REQ-024 awready, wready, arready SHALL be 0 during reset and become 1 on the first rising clk edge after rst_n deasserts.
REQ-025 Reset asserted mid-transaction SHALL abandon it with no register update and no response issued after release.

Configuration
REQ-026 Macro AXI_LITE_SLAVE_SLVERR_EN defined: out-of-range write and read SHALL return bresp/rresp = 2'b10 (SLVERR).
REQ-027 Macro AXI_LITE_SLAVE_SLVERR_EN undefined: out-of-range accesses SHALL return 2'b00 (OKAY), writes ignored, reads 0; in-range behaviour identical either way.

Verification
REQ-028 AW 0x04 and W 0xDEADBEEF strb 0xF same cycle, bready=1 -> reg 1 = 0xDEADBEEF, reg_wr_pulse[1] one cycle, bvalid 2 cycles after handshake, bresp 00.
REQ-029 W 0x000000AA strb 0x1 three cycles before AW 0x04 -> reg 1 low byte = 0xAA, upper bytes unchanged (0xDEADBE AA), wready low after W capture until response.
REQ-030 AR 0x04 with rready=0 for 5 cycles -> rvalid high, rdata stable 0xDEADBEAA, arready 0 until rready accepted.
REQ-031 Write and read to 0x40 (index 16, NUM_REGS=8) -> bresp/rresp 2'b10 with macro, 2'b00 without; rdata 0; no reg_q change.
REQ-032 AR 0x08 captured same cycle as WRITE of 0x12345678 to 0x08 -> rdata returns prior value 0; next read returns 0x12345678.
REQ-033 rst_n low after AW captured, before W -> all outputs 0, readies 1 one edge after release, subsequent write completes normally.
